// File: rtl/aes128_iter_core_if.sv
// aes128_iter_core_if: beat-streaming handshake bundle for the AES core
// master = block source/sink, slave = the core
interface aes128_iter_core_if #(
    parameter int BUS_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] key_in;
    logic [BUS_W-1:0] state_in;
    logic             key_hold;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] state_out;
    logic             busy;

    modport master (
        output in_valid, key_in, state_in, key_hold, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, key_in, state_in, key_hold, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encrypt, one round per cycle
// key and plaintext stream in as BUS_W beats, ciphertext streams out
module subByte (
    input  logic [31:0] word,
    output logic [31:0] sub
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // inverse is b^254 (0 maps to 0), followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]}
                   ^ 8'h63;
    endfunction

    // four independent byte substitutions
    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++)
            sub[31-8*i -: 8] = sbox(word[31-8*i -: 8]);
    end
endmodule

module aes128_iter_core #(
    parameter int BUS_W       = 8,
    parameter bit KEY_HOLD_EN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    aes128_iter_core_if.slave bus
);
    localparam int BEATS = 128 / BUS_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, ROUND, UNLOAD} fsm_t;

    fsm_t          st, st_nx;
    logic [127:0]  state_reg, key_reg, rk;
    logic [127:0]  rk_nx, rnd_nx, sb, sr;
    logic [31:0]   rot_w, sub_w, w0, w1, w2, w3;
    logic [CW-1:0] beat_cnt;
    logic [3:0]    round;
    logic [7:0]    rcon;
    logic          key_valid, hold_blk, hold_now;
    logic          rdy, vld, bsy;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // shift a beat in at the LSB end, oldest beat ends up at the MSB
    function automatic logic [127:0] push(input logic [127:0] r,
                                          input logic [BUS_W-1:0] b);
        logic [127+BUS_W:0] t;
        t = {r, b};
        return t[127:0];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sb
        subByte u_sb (
            .word(state_reg[127-32*g -: 32]),
            .sub (sb[127-32*g -: 32])
        );
    end

    assign rot_w = {rk[23:0], rk[31:24]};

    subByte u_ksb (
        .word(rot_w),
        .sub (sub_w)
    );

    assign hold_now = KEY_HOLD_EN && bus.key_hold && key_valid;

    // on-the-fly key expansion and one full cipher round
    always_comb begin
        w0    = rk[127:96] ^ sub_w ^ {rcon, 24'h0};
        w1    = rk[95:64] ^ w0;
        w2    = rk[63:32] ^ w1;
        w3    = rk[31:0] ^ w2;
        rk_nx = {w0, w1, w2, w3};
        sr    = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        rnd_nx = sr;
        if (round != 4'd10)
            for (int c = 0; c < 4; c++)
                rnd_nx[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
        rnd_nx = rnd_nx ^ rk_nx;
    end

    // control state register
    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    // next state and handshake outputs
    always_comb begin
        st_nx = st;
        rdy   = 1'b0;
        vld   = 1'b0;
        bsy   = 1'b1;
        unique case (st)
            IDLE: begin
                bsy = 1'b0;
                rdy = 1'b1;
                if (bus.in_valid) st_nx = (BEATS == 1) ? INIT : LOAD;
            end
            LOAD: begin
                rdy = 1'b1;
                if (bus.in_valid && beat_cnt == LAST) st_nx = INIT;
            end
            INIT:  st_nx = ROUND;
            ROUND: if (round == 4'd10) st_nx = UNLOAD;
            UNLOAD: begin
                vld = 1'b1;
                if (bus.out_ready && beat_cnt == LAST) st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
        if (rst) begin
            rdy = 1'b0;
            vld = 1'b0;
            bsy = 1'b0;
        end
    end

    // datapath: load shift, round iteration, unload shift
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
            key_reg   <= '0;
            rk        <= '0;
            beat_cnt  <= '0;
            round     <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
            hold_blk  <= 1'b0;
        end else begin
            unique case (st)
                IDLE: if (bus.in_valid) begin
                    state_reg <= push(state_reg, bus.state_in);
                    if (!hold_now) key_reg <= push(key_reg, bus.key_in);
                    hold_blk <= hold_now;
                    beat_cnt <= (BEATS == 1) ? '0 : CW'(1);
                    if (BEATS == 1 && !hold_now) key_valid <= 1'b1;
                end
                LOAD: if (bus.in_valid) begin
                    state_reg <= push(state_reg, bus.state_in);
                    if (!hold_blk) key_reg <= push(key_reg, bus.key_in);
                    if (beat_cnt == LAST) begin
                        beat_cnt <= '0;
                        if (!hold_blk) key_valid <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                INIT: begin
                    state_reg <= state_reg ^ key_reg;
                    rk        <= key_reg;
                    round     <= 4'd1;
                    rcon      <= 8'h01;
                end
                ROUND: begin
                    state_reg <= rnd_nx;
                    rk        <= rk_nx;
                    rcon      <= xtime(rcon);
                    round     <= (round == 4'd10) ? 4'd0 : round + 4'd1;
                end
                UNLOAD: if (bus.out_ready) begin
                    state_reg <= push(state_reg, '0);
                    beat_cnt  <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.busy      = bsy;
    assign bus.state_out = vld ? state_reg[127 -: BUS_W] : '0;
endmodule
